// File: rtl/rv32i_lsu_if.sv
// -----------------------------------------------------------------------------
// rv32i_lsu_if
// Data-memory bus between the RV32I load/store unit and the data memory.
// Request/grant handshake for the address phase, rvalid for read data return.
//
// Signals:
//   mem_req    LSU -> mem  bus request, held until mem_gnt
//   mem_we     LSU -> mem  1 = write, 0 = read
//   mem_addr   LSU -> mem  word-aligned byte address
//   mem_be     LSU -> mem  byte enables, bit n covers mem_wdata[8n+7:8n]
//   mem_wdata  LSU -> mem  lane-aligned store data
//   mem_gnt    mem -> LSU  request accepted this cycle
//   mem_rvalid mem -> LSU  read data valid this cycle
//   mem_rdata  mem -> LSU  read data (full word, LSU extracts the lanes)
//
// Modports: master (LSU side), slave (memory side).
// -----------------------------------------------------------------------------
interface rv32i_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/rv32i_lsu.sv
// -----------------------------------------------------------------------------
// rv32i_lsu
// Load/store unit for the RV32I datapath. Takes the effective address, store
// data and funct3 access size from the core, turns byte/half/word accesses into
// word-aligned bus transactions with byte enables, and returns sign- or
// zero-extended load data to write-back. The core is stalled while an access
// is outstanding.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles spent in REQ+WAIT before bus_err (0 = no watchdog)
//   CNT_W           watchdog counter width, TIMEOUT_CYCLES < 2**CNT_W
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       core presents an access this cycle
//   is_store        1 = store, 0 = load
//   ctrl[2:0]       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (others = word)
//   addr[31:0]      effective byte address
//   wdata[31:0]     store data (rs2)
//   stall           hold the pipeline (req_valid & ~done)
//   done            one-cycle pulse, access complete
//   load_data[31:0] extended load result, valid while done = 1
//   bus_err         one-cycle pulse with done when the watchdog expires
//   misalign_err    (only with LSU_MISALIGN_TRAP_EN) pulse with done on a
//                   misaligned half/word access; the bus is not touched
//   bus             rv32i_lsu_if.master data-memory bus
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses. Without it, misaligned accesses simply use the lane rules and
// ignore the low address bits that do not fit the access size.
// -----------------------------------------------------------------------------
module rv32i_lsu #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        is_store,
    input  logic [2:0]  ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    rv32i_lsu_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam bit             WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_store_q;
    logic [1:0]       size_q;
    logic             unsigned_q;
    logic [1:0]       addr_lo_q;
    logic             done_q;
    logic             bus_err_q;
    logic [31:0]      load_data_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [3:0]       mem_be_q;
    logic [31:0]      mem_wdata_q;

    logic [3:0]       be_lane;
    logic [31:0]      wdata_lane;
    logic [4:0]       shamt;
    logic [31:0]      shifted;
    logic [31:0]      load_ext;
    logic             wd_expire;

    // ctrl[1:0] alone selects the size: 00 byte, 01 half, 1x word. That also
    // folds the undefined codes 011/110/111 into word accesses.
    always_comb begin
        be_lane    = 4'b1111;
        wdata_lane = wdata;
        case (ctrl[1:0])
            2'b00: begin
                be_lane    = 4'b0001 << addr[1:0];
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_lane    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction works on the raw bus word: shift the addressed lane down
    // to bit 0, then sign- or zero-extend according to the latched access.
    always_comb begin
        shamt = 5'd0;
        case (size_q)
            2'b00:   shamt = {addr_lo_q, 3'b000};
            2'b01:   shamt = {addr_lo_q[1], 4'b0000};
            default: ;
        endcase
        shifted  = bus.mem_rdata >> shamt;
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    // The counter is cleared on accept and never exceeds TIMEOUT_CYCLES, so
    // ">=" also catches a load granted on its last allowed REQ cycle.
    assign wd_expire = WD_EN && (cnt_q >= TO_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q;

    assign misaligned   = ((ctrl[1:0] == 2'b01) & addr[0]) |
                          (ctrl[1] & (addr[1:0] != 2'b00));
    assign misalign_err = misalign_q;
`endif

    // Single FSM process; every bus and status output is a register written
    // here. done/bus_err/misalign_err default low so they pulse for exactly
    // the one cycle spent in DONE. Completion events win over the watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            addr_lo_q   <= 2'b00;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            load_data_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q  <= is_store;
                        size_q      <= ctrl[1:0];
                        unsigned_q  <= ctrl[2];
                        addr_lo_q   <= addr[1:0];
                        cnt_q       <= '0;
                        mem_we_q    <= is_store;
                        mem_addr_q  <= {addr[31:2], 2'b00};
                        mem_be_q    <= be_lane;
                        mem_wdata_q <= wdata_lane;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            misalign_q  <= 1'b1;
                            load_data_q <= '0;
                        end else begin
                            state_q   <= REQ;
                            mem_req_q <= 1'b1;
                        end
`else
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (is_store_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (wd_expire) begin
                        mem_req_q   <= 1'b0;
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        bus_err_q   <= 1'b1;
                        load_data_q <= '0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.mem_rvalid) begin
                        load_data_q <= load_ext;
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                    end else if (wd_expire) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        bus_err_q   <= 1'b1;
                        load_data_q <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall         = req_valid & ~done_q;
    assign done          = done_q;
    assign bus_err       = bus_err_q;
    assign load_data     = load_data_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
- Load/store unit directly downstream of the RV32I datapath; consumes its effective address, store data and 3-bit Read/Write control, and drives the data-memory bus.
- Converts byte/half/word accesses into word-aligned bus transactions with byte enables, using a req/gnt/rvalid handshake.
- Returns sign- or zero-extended load data to the write-back mux.
- Holds the core with a stall while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 0, max cycles spent in REQ or WAIT before bus_err; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; TIMEOUT_CYCLES must be < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  datapath presents a load or store this cycle
- is_store  in  1  1=store, 0=load (sampled with req_valid)
- ctrl  in  3  funct3 code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- addr  in  32  effective byte address
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC/pipeline
- done  out  1  one-cycle pulse, access complete
- load_data  out  32  extended load result, valid while done=1
- bus_err  out  1  one-cycle pulse on watchdog expiry (coincides with done)
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). On reset all outputs are 0 except stall, which follows its combinational equation, and the state is IDLE. Reset mid-transaction drops mem_req the next cycle; a pending rvalid is ignored.
- FSM: IDLE, REQ, WAIT, DONE.
  - IDLE: if req_valid, latch is_store, ctrl, addr and wdata, clear the counter, go to REQ.
  - REQ: mem_req=1, with mem_we/addr/be/wdata driven from registers and stable until gnt. On mem_gnt: store goes to DONE, load goes to WAIT.
  - WAIT: on mem_rvalid, capture the extended data and go to DONE. rvalid is honoured only in WAIT; rvalid in the gnt cycle is ignored.
  - DONE: done=1 and load_data held. Next state is IDLE; the request is not re-accepted in this cycle.
- stall = req_valid & ~done (combinational). Minimum latency: store 3 cycles accept-to-done, load 4 cycles.
- Store lanes:
  - byte: mem_wdata = wdata[7:0] replicated x4; mem_be = 4'b0001 << addr[1:0].
  - half: mem_wdata = {wdata[15:0], wdata[15:0]}; mem_be = addr[1] ? 1100 : 0011.
  - word: mem_be = 1111.
- Load extract: shift mem_rdata right by 8*addr[1:0] for byte, 16*addr[1] for half. 000/001 sign-extend, 100/101 zero-extend, 010 passes the word through.
- Undefined ctrl (011, 110, 111) is handled as a word access; no error is flagged.
- Watchdog: if TIMEOUT_CYCLES>0, the counter increments each cycle in REQ/WAIT. On reaching TIMEOUT_CYCLES: go to DONE with bus_err=1, load_data=0 and mem_req deasserted.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: adds output misalign_err (1 bit). Half with addr[0]=1, or word with addr[1:0]!=00, skips the bus entirely. IDLE goes straight to DONE with misalign_err=1, load_data=0 and mem_req never asserted.
- Undefined: the port is absent. Misaligned accesses use the lane rules above, ignoring addr[0] for half and addr[1:0] for word.

Test Plan:
- SB addr=0x1003, wdata=0x000000AB, gnt one cycle after req -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1, done at cycle 3, stall low on the done cycle.
- LB addr=0x2001, mem_rdata=0x1234_80FF, rvalid 2 cycles after gnt -> load_data=0xFFFFFF80. Same access with LBU -> 0x00000080.
- LH addr=0x2002, mem_rdata=0x8001_0000 -> 0xFFFF8001. LW addr=0x2000 -> 0x80010000, mem_be=1111.
- gnt held low 5 cycles -> mem_req and all bus signals stable for 5 cycles, stall high throughout. With TIMEOUT_CYCLES=4 -> bus_err pulse, load_data=0.
- rst asserted while in WAIT, then rvalid arrives -> FSM in IDLE, done never pulses, mem_req=0 the cycle after rst.
- LSU_MISALIGN_TRAP_EN defined, LW addr=0x3002 -> misalign_err=1 and done=1 on the second cycle, mem_req never asserted. Macro undefined -> mem_be=1111, mem_addr=0x3000.
